// File: rtl/package_settings.sv
// Shared settings for the multi-channel moving average: default sizes,
// the FILL/RUN state type and the window clamp helper.
package package_settings;

  localparam int CHANNEL_SIZE                    = 2;
  localparam int SIZE_ADC_DATA                   = 14;
  localparam int SIZE_MOVING_AVERAGE_MAX_WINDOW  = 64;
  localparam int SIZE_MOVING_AVERAGE_WINDOW_LOG2 = 3;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } ma_state_e;

  function automatic logic [SIZE_MOVING_AVERAGE_WINDOW_LOG2-1:0] clamp_window_log2(
    input logic [SIZE_MOVING_AVERAGE_WINDOW_LOG2-1:0] req_log2,
    input logic [SIZE_MOVING_AVERAGE_WINDOW_LOG2-1:0] max_log2
  );
    if (req_log2 > max_log2) begin
      return max_log2;
    end else begin
      return req_log2;
    end
  endfunction

endpackage

// File: rtl/moving_average_delay_line.sv
// Per-channel circular sample history: one write and one registered read per
// accepted sample; the read returns the pre-write contents of the read address.
module moving_average_delay_line #(
  parameter int SIZE_DATA = 14,
  parameter int ADDR_W    = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic [SIZE_DATA-1:0] din,
  output logic [SIZE_DATA-1:0] dout
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [SIZE_DATA-1:0] mem_q [DEPTH];
  logic [SIZE_DATA-1:0] dout_q;
  logic [SIZE_DATA-1:0] dout_d;

  // History contents are never reset; stale entries are masked by the fill logic
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= din;
    end
  end

  // Read port advances only with an accepted sample
  always_comb begin
    if (wr_en) begin
      dout_d = mem_q[rd_addr];
    end else begin
      dout_d = dout_q;
    end
  end

  // Read data register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/moving_average_multi.sv
// Multi-channel power-of-two moving average with FILL/RUN sequencing.
// Pipeline: accept/history read -> running-sum update -> shifted output.
module moving_average_multi
  import package_settings::ma_state_e, package_settings::ST_FILL, package_settings::ST_RUN,
         package_settings::clamp_window_log2, package_settings::SIZE_ADC_DATA,
         package_settings::SIZE_MOVING_AVERAGE_MAX_WINDOW,
         package_settings::SIZE_MOVING_AVERAGE_WINDOW_LOG2;
#(
  parameter int CHANNEL_SIZE         = package_settings::CHANNEL_SIZE,
  parameter int SIZE_DATA            = SIZE_ADC_DATA,
  parameter int SIZE_WINDOW_LOG2_MAX = $clog2(SIZE_MOVING_AVERAGE_MAX_WINDOW)
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic [SIZE_MOVING_AVERAGE_WINDOW_LOG2-1:0] window_log2,
  input  logic [CHANNEL_SIZE*SIZE_DATA-1:0]          data_in,
  input  logic                                       data_valid_in,
  output logic [CHANNEL_SIZE*SIZE_DATA-1:0]          data_out,
  output logic                                       data_valid_out,
  output logic                                       filled
);

  localparam int WLW   = SIZE_MOVING_AVERAGE_WINDOW_LOG2;
  localparam int PW    = SIZE_WINDOW_LOG2_MAX;
  localparam int CW    = SIZE_WINDOW_LOG2_MAX + 1;
  localparam int SUM_W = SIZE_DATA + SIZE_WINDOW_LOG2_MAX;
  localparam logic [WLW-1:0] WL_MAX = WLW'(SIZE_WINDOW_LOG2_MAX);

  logic [WLW-1:0]       wl_q, wl_d, wl_req_s;
  logic                 restart_s;
  logic [CW-1:0]        win_s;
  ma_state_e            state_q, state_d, eff_state_s;
  logic [CW-1:0]        cnt_q, cnt_d, eff_cnt_s;
  logic                 complete_s;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_addr_s;
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_emit_q, s1_emit_d;
  logic                 s1_mask_q, s1_mask_d;
  logic [SIZE_DATA-1:0] s1_x_q [CHANNEL_SIZE];
  logic [SIZE_DATA-1:0] s1_x_d [CHANNEL_SIZE];
  logic [SIZE_DATA-1:0] x_old_s [CHANNEL_SIZE];
  logic [SUM_W-1:0]     sum_q [CHANNEL_SIZE];
  logic [SUM_W-1:0]     sum_d [CHANNEL_SIZE];
  logic                 s2_valid_q, s2_valid_d;
  logic [CHANNEL_SIZE*SIZE_DATA-1:0] dout_q, dout_d;
  logic                 dvo_q, dvo_d;

  // Clamped window request; any change against the active window restarts filling
  always_comb begin
    wl_req_s  = clamp_window_log2(window_log2, WL_MAX);
    restart_s = (wl_req_s != wl_q);
    win_s     = CW'(1) << wl_req_s;
    wl_d      = wl_req_s;
  end

  // FSM next state: a restart behaves as an empty FILL seen by this cycle's sample
  always_comb begin
    eff_state_s = restart_s ? ST_FILL : state_q;
    eff_cnt_s   = restart_s ? '0 : cnt_q;
    state_d     = eff_state_s;
    cnt_d       = eff_cnt_s;
    complete_s  = 1'b0;
    if (data_valid_in) begin
      case (eff_state_s)
        ST_FILL: begin
          cnt_d = eff_cnt_s + CW'(1);
          if (cnt_d == win_s) begin
            complete_s = 1'b1;
            state_d    = ST_RUN;
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_FILL;
      endcase
    end else begin
      state_d = eff_state_s;
    end
  end

  // FSM outputs: per-sample emit and old-sample mask travelling with stage 1
  always_comb begin
    s1_valid_d = data_valid_in;
    s1_emit_d  = data_valid_in & ((eff_state_s == ST_RUN) | complete_s);
    s1_mask_d  = data_valid_in & (eff_state_s == ST_RUN);
  end

  assign filled = (state_q == ST_RUN);

  // Datapath: history addressing, running sums and output shift
  always_comb begin
    wr_ptr_d   = data_valid_in ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_addr_s  = wr_ptr_q - win_s[PW-1:0];
    s2_valid_d = s1_valid_q & s1_emit_q & ~restart_s;
    dvo_d      = s2_valid_q & ~restart_s;
    dout_d     = dout_q;
    for (int c = 0; c < CHANNEL_SIZE; c++) begin
      s1_x_d[c] = data_valid_in ? data_in[c*SIZE_DATA +: SIZE_DATA] : s1_x_q[c];
      if (restart_s) begin
        sum_d[c] = '0;
      end else if (s1_valid_q) begin
        sum_d[c] = sum_q[c] + SUM_W'(s1_x_q[c])
                 - (s1_mask_q ? SUM_W'(x_old_s[c]) : SUM_W'(0));
      end else begin
        sum_d[c] = sum_q[c];
      end
      if (dvo_d) begin
        dout_d[c*SIZE_DATA +: SIZE_DATA] = SIZE_DATA'(sum_q[c] >> wl_q);
      end else begin
        dout_d[c*SIZE_DATA +: SIZE_DATA] = dout_q[c*SIZE_DATA +: SIZE_DATA];
      end
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wl_q       <= '0;
      state_q    <= ST_FILL;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_emit_q  <= 1'b0;
      s1_mask_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      dout_q     <= '0;
      dvo_q      <= 1'b0;
      for (int c = 0; c < CHANNEL_SIZE; c++) begin
        s1_x_q[c] <= '0;
        sum_q[c]  <= '0;
      end
    end else begin
      wl_q       <= wl_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_emit_q  <= s1_emit_d;
      s1_mask_q  <= s1_mask_d;
      s2_valid_q <= s2_valid_d;
      dout_q     <= dout_d;
      dvo_q      <= dvo_d;
      for (int c = 0; c < CHANNEL_SIZE; c++) begin
        s1_x_q[c] <= s1_x_d[c];
        sum_q[c]  <= sum_d[c];
      end
    end
  end

  for (genvar g = 0; g < CHANNEL_SIZE; g++) begin : g_ch
    moving_average_delay_line #(
      .SIZE_DATA (SIZE_DATA),
      .ADDR_W    (PW)
    ) u_delay_line (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (data_valid_in),
      .wr_addr (wr_ptr_q),
      .rd_addr (rd_addr_s),
      .din     (data_in[g*SIZE_DATA +: SIZE_DATA]),
      .dout    (x_old_s[g])
    );
  end

  assign data_out       = dout_q;
  assign data_valid_out = dvo_q;

endmodule

// File: tb/tb_moving_average_multi.sv
// Bench for moving_average_multi: a sample-history model checked every cycle,
// directed scenarios pinned with hand-computed values, then random traffic.
module tb_moving_average_multi;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  window_log2 = 3'd0;
  logic [27:0] data_in = 28'd0;
  logic        data_valid_in = 1'b0;
  logic [27:0] data_out;
  logic        data_valid_out;
  logic        filled;

  moving_average_multi dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .window_log2    (window_log2),
    .data_in        (data_in),
    .data_valid_in  (data_valid_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .filled         (filled)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  // model state: samples accepted since the last restart, plus a 2-deep latency line
  logic [27:0] hist_q[$];
  int          mwl = 0;
  int          req_wl, wsz, s0, s1, nh;
  bit          p0_v, p1_v;
  logic [27:0] p0_d, p1_d;
  bit          exp_dvo, exp_filled;
  logic [27:0] exp_dout = 28'd0;

  int          log_cyc[$];
  logic [27:0] log_val[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset_n) begin
      hist_q.delete();
      mwl = 0; p0_v = 0; p1_v = 0;
      exp_dvo = 0; exp_filled = 0; exp_dout = 28'd0;
    end else begin
      req_wl = (window_log2 > 3'd6) ? 6 : int'(window_log2);
      if (req_wl != mwl) begin
        mwl = req_wl;
        hist_q.delete();
        p0_v = 0; p1_v = 0;
      end
      exp_dvo = p1_v;
      if (p1_v) exp_dout = p1_d;
      p1_v = p0_v; p1_d = p0_d; p0_v = 0;
      wsz = 1 << mwl;
      if (data_valid_in) begin
        hist_q.push_back(data_in);
        if (hist_q.size() > 64) void'(hist_q.pop_front());
        nh = hist_q.size();
        if (nh >= wsz) begin
          s0 = 0; s1 = 0;
          for (int i = nh - wsz; i < nh; i++) begin
            s0 += int'(hist_q[i][13:0]);
            s1 += int'(hist_q[i][27:14]);
          end
          p0_v = 1;
          p0_d = {14'(s1 >> mwl), 14'(s0 >> mwl)};
        end
      end
      exp_filled = (hist_q.size() >= wsz);
    end
    #1;
    chk("valid_out", data_valid_out, exp_dvo);
    chk("filled", filled, exp_filled);
    chk("data_out", data_out, exp_dout);
    if (data_valid_out) begin
      log_cyc.push_back(cyc);
      log_val.push_back(data_out);
    end
  end

  task automatic send(input logic [13:0] a, input logic [13:0] b);
    @(negedge clk);
    data_valid_in = 1'b1;
    data_in = {b, a};
    @(posedge clk);
    #2;
    last_acc = cyc;
    data_valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    data_valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_val.delete();
  endtask

  int c4, bad;
  logic [13:0] va, vb, vc, vd;

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // W=4 ramp on ch0: averages 10 then 14, first 2 cycles after the 4th sample
    window_log2 = 3'd2;
    clear_log();
    send(14'd4, 14'd0); send(14'd8, 14'd0); send(14'd12, 14'd0);
    chk("w4_filled_before", filled, 0);
    send(14'd16, 14'd0);
    c4 = last_acc;
    chk("w4_filled_after", filled, 1);
    send(14'd20, 14'd0);
    idle(4);
    chk("w4_count", log_val.size(), 2);
    if (log_val.size() == 2) begin
      chk("w4_first", log_val[0][13:0], 10);
      chk("w4_second", log_val[1][13:0], 14);
      chk("w4_latency", log_cyc[0] - c4, 2);
    end

    // W=1 gapped: pass-through with 2-cycle latency
    window_log2 = 3'd0;
    idle(2);
    clear_log();
    send(14'd7, 14'd1);
    c4 = last_acc;
    idle(3);
    send(14'd9, 14'd2);
    idle(4);
    chk("w1_count", log_val.size(), 2);
    if (log_val.size() == 2) begin
      chk("w1_first", log_val[0], {14'd1, 14'd7});
      chk("w1_second", log_val[1], {14'd2, 14'd9});
      chk("w1_latency", log_cyc[0] - c4, 2);
    end

    // W=64 full-scale constant: 63 silent samples, then 16383 without overflow
    window_log2 = 3'd6;
    idle(2);
    clear_log();
    repeat (63) send(14'h3FFF, 14'h3FFF);
    idle(3);
    chk("w64_silent", log_val.size(), 0);
    chk("w64_not_filled", filled, 0);
    repeat (8) send(14'h3FFF, 14'h3FFF);
    idle(4);
    chk("w64_count", log_val.size(), 8);
    bad = 0;
    foreach (log_val[i]) if (log_val[i] != {14'h3FFF, 14'h3FFF}) bad++;
    chk("w64_values", bad, 0);

    // RUN at W=8, switch to W=4 mid-stream: in-flight dropped, then mean of 4 new
    window_log2 = 3'd3;
    repeat (12) send(14'($urandom), 14'($urandom));
    clear_log();
    window_log2 = 3'd2;
    va = 14'd100; vb = 14'd201; vc = 14'd302; vd = 14'd403;
    send(va, vd);
    chk("switch_filled_low", filled, 0);
    send(vb, vc); send(vc, vb); send(vd, va);
    idle(4);
    chk("switch_count", log_val.size(), 1);
    if (log_val.size() == 1) begin
      chk("switch_mean", log_val[0], {14'd251, 14'd251});
    end

    // window_log2=7 clamps to 64; channels stay independent
    window_log2 = 3'd7;
    idle(2);
    clear_log();
    repeat (70) send(14'd100, 14'd0);
    idle(4);
    chk("clamp_count", log_val.size(), 7);
    bad = 0;
    foreach (log_val[i]) if (log_val[i] != {14'd0, 14'd100}) bad++;
    chk("clamp_values", bad, 0);

    // Async reset mid-RUN
    window_log2 = 3'd2;
    repeat (6) send(14'($urandom), 14'($urandom));
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", data_valid_out, 0);
    chk("rst_filled", filled, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    repeat (3) send(14'd50, 14'd60);
    idle(3);
    chk("rst_refill_silent", log_val.size(), 0);
    send(14'd70, 14'd80);
    idle(3);
    chk("rst_refill_count", log_val.size(), 1);
    if (log_val.size() == 1) begin
      chk("rst_refill_mean", log_val[0], {14'd65, 14'd55});
    end

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 1499) == 0) begin
        reset_n = 1'b0;
        data_valid_in = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
      if ($urandom_range(0, 149) == 0) window_log2 = 3'($urandom_range(0, 7));
      data_valid_in = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) data_in = {14'h3FFF, 14'h3FFF};
      else data_in = {14'($urandom), 14'($urandom)};
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
